// File: rtl/mat_mul_ctrl.sv
// Matrix-multiply sequencer: drives one shared multi-cycle multiplier over
// valid/ready and streams C = A x B elements out in row-major order.
module mat_mul_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N      = 2,
  parameter int unsigned ACC_W  = 2*DATA_W + $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [N*N*DATA_W-1:0]      ld_a,
  input  logic [N*N*DATA_W-1:0]      ld_b,
  output logic                       mul_in_valid,
  input  logic                       mul_in_ready,
  output logic [DATA_W-1:0]          mul_op1,
  output logic [DATA_W-1:0]          mul_op2,
  input  logic [2*DATA_W-1:0]        mul_dout,
  input  logic                       mul_out_valid,
  output logic                       mul_out_ready,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ACC_W-1:0]           res_data,
  output logic [$clog2(N)-1:0]       res_row,
  output logic [$clog2(N)-1:0]       res_col,
  output logic                       res_last,
  output logic                       busy
);

  localparam int unsigned IDX_W  = $clog2(N);
  localparam int unsigned SEL_W  = $clog2(N*N);
  localparam int unsigned PROD_W = 2*DATA_W;
  localparam int unsigned EXT_W  = ACC_W - PROD_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [N*N-1:0][DATA_W-1:0] a_q;
  logic [N*N-1:0][DATA_W-1:0] b_q;
  logic [IDX_W-1:0]           i, j, k;
  logic [ACC_W-1:0]           acc;

  logic [SEL_W-1:0]           a_sel, b_sel;
  logic [ACC_W-1:0]           prod_ext;
  logic                       k_last, j_last, i_last, last_elem;

  assign k_last    = (k == IDX_W'(N-1));
  assign j_last    = (j == IDX_W'(N-1));
  assign i_last    = (i == IDX_W'(N-1));
  assign last_elem = i_last && j_last;

  // Flat element indices: A[i][k] and B[k][j]
  assign a_sel    = SEL_W'(i) * SEL_W'(N) + SEL_W'(k);
  assign b_sel    = SEL_W'(k) * SEL_W'(N) + SEL_W'(j);
  assign prod_ext = {{EXT_W{mul_dout[PROD_W-1]}}, mul_dout};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ld_valid)      state_nxt = S_ISSUE;
      S_ISSUE: if (mul_in_ready)  state_nxt = S_WAIT;
      S_WAIT:  if (mul_out_valid) state_nxt = k_last ? S_EMIT : S_ISSUE;
      S_EMIT:  if (res_ready)     state_nxt = last_elem ? S_IDLE : S_ISSUE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // Operand copies, loop counters and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      i   <= '0;
      j   <= '0;
      k   <= '0;
      acc <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ld_valid) begin
            a_q <= ld_a;
            b_q <= ld_b;
            i   <= '0;
            j   <= '0;
            k   <= '0;
          end
        end
        S_WAIT: begin
          if (mul_out_valid) begin
            acc <= (k == '0) ? prod_ext : acc + prod_ext;
            if (!k_last) k <= k + IDX_W'(1);
          end
        end
        S_EMIT: begin
          if (res_ready && !last_elem) begin
            k <= '0;
            if (j_last) begin
              j <= '0;
              i <= i + IDX_W'(1);
            end else begin
              j <= j + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and registers only
  assign ld_ready      = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign mul_in_valid  = (state == S_ISSUE);
  assign mul_out_ready = (state == S_WAIT);
  assign res_valid     = (state == S_EMIT);
  assign res_last      = (state == S_EMIT) && last_elem;
  assign mul_op1       = a_q[a_sel];
  assign mul_op2       = b_q[b_sel];
  assign res_data      = acc;
  assign res_row       = i;
  assign res_col       = j;

endmodule

// File: tb/tb_mat_mul_ctrl.sv
// Self-checking bench for mat_mul_ctrl: behavioural multiplier plus matrix
// reference model, randomized stalls and data.
module tb_mat_mul_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned N      = 2;
  localparam int unsigned ACC_W  = 2*DATA_W + $clog2(N);
  localparam int unsigned IW     = $clog2(N);
  localparam int unsigned MW     = N*N*DATA_W;
  localparam int unsigned PW     = 2*DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_valid;
  logic              ld_ready;
  logic [MW-1:0]     ld_a, ld_b;
  logic              mul_in_valid, mul_in_ready;
  logic [DATA_W-1:0] mul_op1, mul_op2;
  logic [PW-1:0]     mul_dout;
  logic              mul_out_valid, mul_out_ready;
  logic              res_valid, res_ready;
  logic [ACC_W-1:0]  res_data;
  logic [IW-1:0]     res_row, res_col;
  logic              res_last;
  logic              busy;

  int checks = 0;
  int errors = 0;

  mat_mul_ctrl #(.DATA_W(DATA_W), .N(N), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_a(ld_a), .ld_b(ld_b),
    .mul_in_valid(mul_in_valid), .mul_in_ready(mul_in_ready),
    .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mul_dout(mul_dout), .mul_out_valid(mul_out_valid), .mul_out_ready(mul_out_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_col(res_col), .res_last(res_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] mk(input int e0, input int e1, input int e2, input int e3);
    return {DATA_W'(e3), DATA_W'(e2), DATA_W'(e1), DATA_W'(e0)};
  endfunction

  function automatic int el(input logic [MW-1:0] m, input int idx);
    logic signed [DATA_W-1:0] v;
    v = m[idx*DATA_W +: DATA_W];
    return int'(v);
  endfunction

  function automatic int rnd_elem();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // One full job (or an aborted one when abort_hs >= 0). Entered and left on a negedge.
  task automatic run_job(input logic [MW-1:0] a, input logic [MW-1:0] b,
                         input int in_max, input int out_max, input int res_max,
                         input bit rnd, input int abort_hs);
    int ops1[$];
    int ops2[$];
    int cexp[$];
    int hs = 0, res_idx = 0, cyc = 0;
    int in_cnt = 0, in_tgt = 0, lat_cnt = 0, res_cnt = 0, res_tgt = 0, pend = 0;
    bit have_op = 0, have_res = 0, done = 0;
    logic [DATA_W-1:0] sop1, sop2;
    logic [ACC_W-1:0]  sdata;
    logic [IW-1:0]     srow, scol;
    logic              slast;
    logic [ACC_W-1:0]  edata;
    bit                elast;

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        int sum = 0;
        for (int kk = 0; kk < N; kk++) begin
          ops1.push_back(el(a, r*N + kk));
          ops2.push_back(el(b, kk*N + c));
          sum += el(a, r*N + kk) * el(b, kk*N + c);
        end
        cexp.push_back(sum);
      end

    res_ready = 1'b0; mul_in_ready = 1'b0; mul_out_valid = 1'b0; ld_valid = 1'b0;
    checks++;
    if (ld_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_idle ld_ready=%b busy=%b expected 1,0", ld_ready, busy);
    end
    ld_valid = 1'b1; ld_a = a; ld_b = b;
    @(negedge clk);
    ld_valid = 1'b0; ld_a = MW'($urandom); ld_b = MW'($urandom);
    checks++;
    if (busy !== 1'b1 || mul_in_valid !== 1'b1) begin
      errors++;
      $display("FAIL load_start busy=%b mul_in_valid=%b expected 1,1", busy, mul_in_valid);
    end

    while (!done && cyc < 3000) begin
      cyc++;
      mul_in_ready = 1'b0; res_ready = 1'b0; mul_out_valid = 1'b0;
      checks++;
      if ($countones({mul_in_valid, mul_out_ready, res_valid}) != 1 || ld_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL phase_flags in_v=%b out_r=%b res_v=%b ld_ready=%b busy=%b expected one-hot,0,1",
                 mul_in_valid, mul_out_ready, res_valid, ld_ready, busy);
      end
      // Loads offered while busy must be ignored
      ld_valid = ($urandom_range(0, 3) == 0);
      ld_a = MW'($urandom); ld_b = MW'($urandom);

      if (abort_hs >= 0 && hs == abort_hs && mul_out_ready === 1'b1) begin
        rst = 1'b1;
        mul_out_valid = 1'b1; mul_dout = PW'($urandom);
        @(negedge clk);
        rst = 1'b0; ld_valid = 1'b0; mul_out_valid = 1'b0;
        checks++;
        if ({ld_ready, busy, mul_in_valid, mul_out_ready, res_valid, res_last} !== 6'b100000) begin
          errors++;
          $display("FAIL abort_flags got %b expected 100000",
                   {ld_ready, busy, mul_in_valid, mul_out_ready, res_valid, res_last});
        end
        checks++;
        if ({mul_op1, mul_op2, res_data, res_row, res_col} !== '0) begin
          errors++;
          $display("FAIL abort_data op1=%h op2=%h data=%h row=%h col=%h expected 0",
                   mul_op1, mul_op2, res_data, res_row, res_col);
        end
        return;
      end

      if (mul_in_valid === 1'b1) begin
        if (!have_op) begin
          have_op = 1; sop1 = mul_op1; sop2 = mul_op2; in_cnt = 0;
          in_tgt = rnd ? int'($urandom_range(0, in_max)) : in_max;
          checks++;
          if (hs >= ops1.size()) begin
            errors++;
            $display("FAIL extra_issue hs=%0d expected at most %0d", hs, ops1.size());
          end else if (sop1 !== DATA_W'(ops1[hs]) || sop2 !== DATA_W'(ops2[hs])) begin
            errors++;
            $display("FAIL operands hs=%0d got %0d,%0d expected %0d,%0d",
                     hs, $signed(sop1), $signed(sop2), ops1[hs], ops2[hs]);
          end
        end else begin
          checks++;
          if (mul_op1 !== sop1 || mul_op2 !== sop2) begin
            errors++;
            $display("FAIL op_stable got %h,%h expected %h,%h", mul_op1, mul_op2, sop1, sop2);
          end
        end
        if (in_cnt >= in_tgt) begin
          mul_in_ready = 1'b1;
          pend = (hs < ops1.size()) ? ops1[hs] * ops2[hs] : 0;
          hs++; have_op = 0;
          lat_cnt = rnd ? int'($urandom_range(0, out_max)) : out_max;
        end else begin
          in_cnt++;
        end
      end

      if (mul_out_ready === 1'b1) begin
        if (lat_cnt > 0) begin
          lat_cnt--; mul_dout = PW'($urandom);
        end else begin
          mul_out_valid = 1'b1; mul_dout = PW'(pend);
        end
      end else begin
        // Junk on the result port outside WAIT must not be consumed
        mul_out_valid = $urandom_range(0, 1) == 1; mul_dout = PW'($urandom);
      end

      if (res_valid === 1'b1) begin
        if (!have_res) begin
          have_res = 1; sdata = res_data; srow = res_row; scol = res_col; slast = res_last;
          res_cnt = 0;
          res_tgt = rnd ? int'($urandom_range(0, res_max)) : res_max;
          edata = ACC_W'(cexp[res_idx]);
          elast = (res_idx == N*N - 1);
          checks++;
          if (sdata !== edata || srow !== IW'(res_idx / N) || scol !== IW'(res_idx % N) || slast !== elast) begin
            errors++;
            $display("FAIL result idx=%0d got data=%0d row=%0d col=%0d last=%b expected %0d,%0d,%0d,%b",
                     res_idx, $signed(sdata), srow, scol, slast, cexp[res_idx],
                     res_idx / N, res_idx % N, elast);
          end
        end else begin
          checks++;
          if (res_data !== sdata || res_row !== srow || res_col !== scol || res_last !== slast) begin
            errors++;
            $display("FAIL res_stable got %h,%h,%h,%b expected %h,%h,%h,%b",
                     res_data, res_row, res_col, res_last, sdata, srow, scol, slast);
          end
        end
        if (res_cnt >= res_tgt) begin
          res_ready = 1'b1; have_res = 0; res_idx++;
          if (res_idx == N*N) done = 1;
        end else begin
          res_cnt++;
        end
      end
      @(negedge clk);
    end

    res_ready = 1'b0; mul_in_ready = 1'b0; mul_out_valid = 1'b0; ld_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout results=%0d expected %0d", res_idx, N*N);
    end
    checks++;
    if (ld_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL end_idle ld_ready=%b busy=%b res_valid=%b expected 1,0,0", ld_ready, busy, res_valid);
    end
    checks++;
    if (hs != N*N*N) begin
      errors++;
      $display("FAIL issue_count got %0d expected %0d", hs, N*N*N);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_valid = 1'b0; ld_a = '0; ld_b = '0;
    mul_in_ready = 1'b0; mul_out_valid = 1'b0; mul_dout = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ld_ready, busy, mul_in_valid, mul_out_ready, res_valid, res_last} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags got %b expected 100000",
               {ld_ready, busy, mul_in_valid, mul_out_ready, res_valid, res_last});
    end
    checks++;
    if ({mul_op1, mul_op2, res_data, res_row, res_col} !== '0) begin
      errors++;
      $display("FAIL reset_data op1=%h op2=%h data=%h row=%h col=%h expected 0",
               mul_op1, mul_op2, res_data, res_row, res_col);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    run_job(mk(1, 2, 3, 4), mk(1, 0, 0, 1), 0, 0, 0, 1'b0, -1);
  endtask

  task automatic test_signed();
    run_job(mk(-1, 2, 3, -4), mk(5, -6, -7, 8), 0, 1, 0, 1'b0, -1);
  endtask

  task automatic test_extremes();
    run_job(mk(-128, -128, -128, -128), mk(-128, -128, -128, -128), 0, 0, 0, 1'b0, -1);
    run_job(mk(127, 127, 127, 127), mk(-128, -128, -128, -128), 0, 2, 0, 1'b0, -1);
  endtask

  task automatic test_stalls();
    run_job(mk(-1, 2, 3, -4), mk(5, -6, -7, 8), 5, 4, 0, 1'b0, -1);
  endtask

  task automatic test_res_stall();
    run_job(mk(7, -3, 0, 9), mk(-2, 11, 4, -5), 0, 0, 3, 1'b0, -1);
  endtask

  task automatic test_mid_reset();
    run_job(mk(1, 2, 3, 4), mk(1, 0, 0, 1), 0, 3, 0, 1'b0, 3);
    run_job(mk(1, 2, 3, 4), mk(1, 0, 0, 1), 0, 0, 0, 1'b0, -1);
  endtask

  task automatic test_back_to_back_random();
    for (int n = 0; n < 20; n++)
      run_job(mk(rnd_elem(), rnd_elem(), rnd_elem(), rnd_elem()),
              mk(rnd_elem(), rnd_elem(), rnd_elem(), rnd_elem()), 3, 3, 2, 1'b1, -1);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_signed();
    test_extremes();
    test_stalls();
    test_res_stall();
    test_mid_reset();
    test_back_to_back_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
